// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the data-memory port of
// mem_arbiter.
//   req0/1, wr0/1, addr0/1, wdata0/1 : requester transaction request
//   rdata0/1, ready0/1, err0/1       : requester completion response
//   mem_addr, mem_wdata, mem_w_en, mem_r_en, mem_rdata : data-memory port
//   busy                             : arbiter not idle
// modport slave is the arbiter side; modport master is the requester/memory side.
interface mem_arbiter_if;
  localparam int unsigned DATA_W = 32;

  logic              req0;
  logic              req1;
  logic              wr0;
  logic              wr1;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              ready0;
  logic              ready1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_w_en;
  logic              mem_r_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output rdata0, rdata1, ready0, ready1, err0, err1,
           mem_addr, mem_wdata, mem_w_en, mem_r_en, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  rdata0, rdata1, ready0, ready1, err0, err1,
           mem_addr, mem_wdata, mem_w_en, mem_r_en, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting two requesters single-transaction
// access to a word-addressed data memory with a fixed access latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester 0/1 ports, memory port, busy)
// Parameters: BASE_ADDR (byte address of word 0), DEPTH (words),
//             WAIT_CYCLES (ACCESS cycles per transaction, 1..15).
module mem_arbiter #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [DATA_W-1:0] LP_ADDR_LO = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] LP_ADDR_HI = DATA_W'(BASE_ADDR + 4 * DEPTH - 1);
  localparam logic [CNT_W-1:0]  LP_CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic              LP_ONE_WAIT = (WAIT_CYCLES == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last_gnt;
  logic               r_gnt;
  logic               r_wr;
  logic [DATA_W-1:0]  r_rdata0;
  logic [DATA_W-1:0]  r_rdata1;
  logic               r_ready0;
  logic               r_ready1;
  logic               r_err0;
  logic               r_err1;
  logic [DATA_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_w_en;
  logic               r_mem_r_en;
  logic               r_busy;

  logic               w_any_req;
  logic               w_grant;
  logic               w_sel_wr;
  logic [DATA_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_addr_ok;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Round-robin pick and selection of the winner's request fields.
  always_comb begin
    w_any_req   = bus.req0 | bus.req1;
    w_grant     = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_grant = ~r_last_gnt;
    end else begin
      w_grant = bus.req1;
    end
    w_sel_wr    = w_grant ? bus.wr1    : bus.wr0;
    w_sel_addr  = w_grant ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_grant ? bus.wdata1 : bus.wdata0;
    w_addr_ok   = (w_sel_addr >= LP_ADDR_LO) && (w_sel_addr <= LP_ADDR_HI) &&
                  (w_sel_addr[1:0] == 2'b00);
    w_cnt_nxt   = r_cnt + CNT_W'(1);
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_gnt  <= 1'b1;  // requester 0 wins the first tie
      r_gnt       <= 1'b0;
      r_wr        <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_ready0    <= 1'b0;
      r_ready1    <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_w_en  <= 1'b0;
      r_mem_r_en  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_grant;
            r_last_gnt <= w_grant;
            r_wr       <= w_sel_wr;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            if (w_addr_ok) begin
              r_state     <= S_ACCESS;
              r_mem_addr  <= w_sel_addr;
              r_mem_wdata <= w_sel_wdata;
              r_mem_r_en  <= ~w_sel_wr;
              // With a single ACCESS cycle the first cycle is also the write cycle.
              r_mem_w_en  <= w_sel_wr & LP_ONE_WAIT;
            end else begin
              // Rejected: answer straight away, memory port untouched.
              r_state <= S_DONE;
              if (w_grant) begin
                r_ready1 <= 1'b1;
                r_err1   <= 1'b1;
              end else begin
                r_ready0 <= 1'b1;
                r_err0   <= 1'b1;
              end
            end
          end
        end

        S_ACCESS: begin
          if (r_cnt == LP_CNT_LAST) begin
            r_state    <= S_DONE;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            if (r_gnt) begin
              r_ready1 <= 1'b1;
              r_rdata1 <= r_wr ? '0 : bus.mem_rdata;
            end else begin
              r_ready0 <= 1'b1;
              r_rdata0 <= r_wr ? '0 : bus.mem_rdata;
            end
          end else begin
            r_cnt      <= w_cnt_nxt;
            // Arm the write enable only for the final ACCESS cycle.
            r_mem_w_en <= r_wr && (w_cnt_nxt == LP_CNT_LAST);
          end
        end

        S_DONE: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_ready0 <= 1'b0;
          r_ready1 <= 1'b0;
          r_err0   <= 1'b0;
          r_err1   <= 1'b0;
          r_rdata0 <= '0;
          r_rdata1 <= '0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.ready0    = r_ready0;
  assign bus.ready1    = r_ready1;
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_w_en  = r_mem_w_en;
  assign bus.mem_r_en  = r_mem_r_en;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural data memory and an in-order response scoreboard.
module tb_mem_arbiter;

  localparam int unsigned BASE  = 1024;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .BASE_ADDR  (BASE),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural data memory: not cleared by rst_n.
  logic [31:0] mem [DEPTH];
  logic [5:0]  mem_idx;
  assign mem_idx       = 6'((bus.mem_addr - 32'(BASE)) >> 2);
  assign bus.mem_rdata = bus.mem_r_en ? mem[mem_idx] : 32'h0;
  always @(posedge clk) if (bus.mem_w_en) mem[mem_idx] <= bus.mem_wdata;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_wen    = 0;
  int   n_ren    = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every ready pulse.
  always @(negedge clk) begin
    if (bus.mem_w_en) n_wen++;
    if (bus.mem_r_en) n_ren++;
    if (bus.ready0 || bus.ready1) begin
      check("ready_overlap", 32'(bus.ready0 & bus.ready1), 32'h0);
      if (sb.size() == 0) begin
        check("unexpected_ready", {30'h0, bus.ready1, bus.ready0}, 32'h0);
      end else begin
        e_mon = sb.pop_front();
        check("ready_id", 32'(bus.ready1), 32'(e_mon.id));
        if (e_mon.id) begin
          check("rdata1", bus.rdata1, e_mon.rdata);
          check("err1", 32'(bus.err1), 32'(e_mon.err));
          check("ungranted0_quiet", bus.rdata0 | 32'(bus.err0), 32'h0);
        end else begin
          check("rdata0", bus.rdata0, e_mon.rdata);
          check("err0", 32'(bus.err0), 32'(e_mon.err));
          check("ungranted1_quiet", bus.rdata1 | 32'(bus.err1), 32'h0);
        end
      end
    end else begin
      check("idle_outputs_quiet", bus.rdata0 | bus.rdata1 | 32'(bus.err0 | bus.err1), 32'h0);
    end
  end

  // One transaction from requester id; req is dropped in the ready cycle.
  task automatic txn(input logic id, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    if (id) begin
      bus.req1 = 1'b1; bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = wdata;
    end
    sb.push_back('{id, exp_rdata, exp_err});
    @(posedge clk);
    #1;
    // Post-grant changes must be ignored.
    if (id) begin
      bus.wr1 = ~wr; bus.addr1 = ~addr; bus.wdata1 = ~wdata;
    end else begin
      bus.wr0 = ~wr; bus.addr0 = ~addr; bus.wdata0 = ~wdata;
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? bus.ready1 : bus.ready0) break;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c_r0, c_r1, n_r0, n_r1, idle_cnt, wen_s, ren_s;
    bit started;
    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h1000_0000 + 32'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ready", {30'h0, bus.ready1, bus.ready0}, 32'h0);
    check("rst_mem_en", {30'h0, bus.mem_w_en, bus.mem_r_en}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;

    // Write then read back through requester 0
    wen_s = n_wen;
    txn(1'b0, 1'b1, 32'd1024, 32'd10, 32'h0, 1'b0, WAITC, "wr1024");
    check("wr1024_wen_cycles", 32'(n_wen - wen_s), 32'd1);
    txn(1'b0, 1'b0, 32'd1024, 32'h0, 32'd10, 1'b0, WAITC, "rd1024");

    // Rejected addresses: no memory activity, immediate answer
    wen_s = n_wen; ren_s = n_ren;
    txn(1'b0, 1'b0, 32'd1029, 32'h0, 32'h0, 1'b1, 0, "rd1029");
    txn(1'b0, 1'b0, 32'd1020, 32'h0, 32'h0, 1'b1, 0, "rd1020");
    txn(1'b1, 1'b1, 32'd1280, 32'h77, 32'h0, 1'b1, 0, "wr1280");
    check("bad_addr_no_wen", 32'(n_wen - wen_s), 32'h0);
    check("bad_addr_no_ren", 32'(n_ren - ren_s), 32'h0);

    // Last valid word
    txn(1'b1, 1'b0, 32'd1276, 32'h0, 32'h1000_003F, 1'b0, WAITC, "rd1276");
    txn(1'b1, 1'b1, 32'd1276, 32'h55AA, 32'h0, 1'b0, WAITC, "wr1276");
    txn(1'b0, 1'b0, 32'd1276, 32'h0, 32'h55AA, 1'b0, WAITC, "rd1276_new");

    // Tie right after reset: requester 0 first, then 1
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'd1032;
    bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 32'd1036;
    sb.push_back('{1'b0, 32'h1000_0002, 1'b0});
    sb.push_back('{1'b1, 32'h1000_0003, 1'b0});
    c0 = cyc; c_r0 = -1; c_r1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready0) begin c_r0 = cyc; bus.req0 = 0; end
      if (bus.ready1) begin c_r1 = cyc; bus.req1 = 0; break; end
    end
    bus.req0 = 0; bus.req1 = 0;
    check("tie_ready0_cycle", 32'(c_r0 - c0), 32'(WAITC + 1));
    check("tie_ready1_cycle", 32'(c_r1 - c0), 32'(2 * WAITC + 3));

    // Both hold req for six transactions: grants alternate 0,1,...
    @(negedge clk);
    @(negedge clk);
    bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 32'd1040;
    bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 32'd1044;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, 32'h1000_0004, 1'b0});
      sb.push_back('{1'b1, 32'h1000_0005, 1'b0});
    end
    n_r0 = 0; n_r1 = 0; idle_cnt = 0; started = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.ready0) begin n_r0++; started = 1; if (n_r0 == 3) bus.req0 = 0; end
      if (bus.ready1) begin n_r1++; if (n_r1 == 3) bus.req1 = 0; end
      if (n_r0 + n_r1 == 6) break;
      if (started && !bus.busy) idle_cnt++;
    end
    bus.req0 = 0; bus.req1 = 0;
    check("rr_total_ready", 32'(n_r0 + n_r1), 32'd6);
    check("rr_idle_gaps", 32'(idle_cnt), 32'd5);

    // Reset during the first ACCESS cycle of a write
    @(negedge clk);
    @(negedge clk);
    bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 32'd1028; bus.wdata1 = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'h1);
    wen_s = n_wen;
    rst_n = 1'b0;
    bus.req1 = 0;
    #1;
    check("abort_busy_async", 32'(bus.busy), 32'h0);
    check("abort_mem_en_async", {30'h0, bus.mem_w_en, bus.mem_r_en}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_write", 32'(n_wen - wen_s), 32'h0);
    txn(1'b1, 1'b0, 32'd1028, 32'h0, 32'h1000_0001, 1'b0, WAITC, "rd1028_after_abort");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 1024, byte address of data-memory word 0.
REQ-002 Parameter DEPTH, default 64, number of 32-bit words in data memory.
REQ-003 Parameter WAIT_CYCLES, default 2, range 1..15, number of ACCESS cycles per transaction.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req0 / req1  in  1  requester i transaction request, level, held until ready_i.
REQ-007 wr0 / wr1  in  1  requester i write (1) or read (0).
REQ-008 addr0 / addr1  in  32  requester i byte address.
REQ-009 wdata0 / wdata1  in  32  requester i store value.
REQ-010 rdata0 / rdata1  out  32  requester i load value, valid while ready_i=1.
REQ-011 ready0 / ready1  out  1  one-cycle completion pulse to requester i.
REQ-012 err0 / err1  out  1  with ready_i, transaction rejected (bad address).
REQ-013 mem_addr  out  32  address to data memory.
REQ-014 mem_wdata  out  32  store value to data memory.
REQ-015 mem_w_en  out  1  memory write enable; memory writes on the rising edge when 1.
REQ-016 mem_r_en  out  1  memory read enable.
REQ-017 mem_rdata  in  32  memory load value, combinational from mem_addr when mem_r_en=1.
REQ-018 busy  out  1  1 in any state other than IDLE.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; one transaction in flight at a time.
REQ-020 IDLE: if any req_i=1, grant one, latch its wr/addr/wdata and grant index; go to ACCESS, or to DONE if the address is invalid.
REQ-021 Valid address: BASE_ADDR <= addr <= BASE_ADDR+4*DEPTH-1 and addr[1:0]=0; otherwise invalid.
REQ-022 Arbitration round-robin: single request wins; both requesting -> requester not granted last wins; after reset requester 0 wins the first tie.
REQ-023 ACCESS: lasts exactly WAIT_CYCLES cycles, counted by an internal counter; mem_addr/mem_wdata driven from latched values throughout.
REQ-024 Read in ACCESS: mem_r_en=1 every ACCESS cycle; mem_rdata captured into the response register at the end of the last ACCESS cycle.
REQ-025 Write in ACCESS: mem_w_en=1 only in the last ACCESS cycle (exactly one write edge per transaction); mem_r_en=0.
REQ-026 Outside ACCESS: mem_w_en=0, mem_r_en=0, mem_addr and mem_wdata hold their last values.
REQ-027 DONE: one cycle; ready_g=1 for the granted requester only; rdata_g = captured data for a valid read, 0 for writes and errors; err_g=1 iff invalid; then IDLE.
REQ-028 Ungranted requester: ready, err 0 and rdata 0 at all times.
REQ-029 Latency: req sampled at edge k (end of IDLE cycle) -> ready in cycle k+WAIT_CYCLES+1; invalid address -> ready/err in cycle k+1.
REQ-030 req_i, wr_i, addr_i, wdata_i changes after grant are ignored until DONE.
REQ-031 Requester drops req_i at the edge ending its ready cycle; a req_i still high in the following IDLE cycle is a new transaction.
REQ-032 A losing requester keeps req high and is served next (no starvation: wait at most one transaction).
REQ-033 Invalid-address transactions perform no memory access and count as a grant for round-robin.

Reset
REQ-034 rst_n=0 forces immediately, without clk: state IDLE, counter 0, last-grant pointer such that requester 0 wins the next tie, all outputs 0.
REQ-035 Reset asserted mid-ACCESS abandons the transaction: no ready, no further mem_w_en; a write whose final edge has not occurred is not performed.
REQ-036 After rst_n rises, first transaction accepted in the first IDLE cycle.

Verification
REQ-037 req0 write addr0=1024 wdata0=10, then read 1024 -> mem_w_en one cycle, later ready0 with rdata0=10, err0=0, ready in cycle k+3 (WAIT_CYCLES=2).
REQ-038 req0 and req1 both read in the same cycle after reset -> requester 0 served first, requester 1 next, ready pulses never overlap.
REQ-039 req0 read addr 1029 (misaligned) and addr 1020 (below base) -> ready0=err0=1 in cycle k+1, rdata0=0, mem_r_en/mem_w_en never 1.
REQ-040 req1 write addr1=1028 wdata1=32'hDEAD_BEEF, rst_n pulsed low during first ACCESS cycle -> no ready1, mem_w_en stays 0, following read of 1028 returns old contents.
REQ-041 Both requesters hold req continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; busy low exactly one cycle between transactions.
